// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: default width, FSM state
// encoding and the quotient reported on a zero divisor.
package iter_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
//   start/is_signed/dividend/divisor/cancel : request side, driven by master
//   busy/done/div_by_zero/lo/hi             : result side, driven by divider
interface iter_divider_if #(
    parameter int unsigned WIDTH = iter_divider_pkg::DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    modport master (
        output start, is_signed, dividend, divisor, cancel,
        input  busy, done, div_by_zero, lo, hi
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel,
        output busy, done, div_by_zero, lo, hi
    );

endinterface

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder (WIDTH+1 bits, ~divisor with carry-in 1) built from 4-bit
// carry-lookahead groups, followed by the restore mux.
//   rem_sh     : {partial remainder, next dividend bit}
//   divisor    : divisor magnitude
//   rem_next_c : new partial remainder
//   q_bit_c    : quotient bit (carry out of the subtract, i.e. no borrow)
module div_sub_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_sh,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    localparam int unsigned PAD_W = ((WIDTH + 1 + 3) / 4) * 4;
    localparam int unsigned NGRP  = PAD_W / 4;

    logic [PAD_W-1:0]       a_pad_c;
    logic [PAD_W-1:0]       b_pad_c;
    logic [PAD_W-1:0]       sum_c;
    logic                   carry_c;
    logic [3:0]             grp_g_c;
    logic [3:0]             grp_p_c;
    logic [4:0]             grp_c_c;
    logic [PAD_W-WIDTH-1:0] unused_sum_c;

    // Padding: minuend zero-extended, inverted subtrahend one-filled, so the
    // pad bits only propagate and the top carry equals the WIDTH+1-bit carry.
    assign a_pad_c = PAD_W'(rem_sh);
    assign b_pad_c = ~(PAD_W'(divisor));

    // Carry-lookahead inside each 4-bit group, groups chained by their carry.
    always_comb begin
        sum_c   = '0;
        carry_c = 1'b1;
        grp_g_c = '0;
        grp_p_c = '0;
        grp_c_c = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            grp_g_c    = a_pad_c[4*g +: 4] & b_pad_c[4*g +: 4];
            grp_p_c    = a_pad_c[4*g +: 4] ^ b_pad_c[4*g +: 4];
            grp_c_c[0] = carry_c;
            grp_c_c[1] = grp_g_c[0] | (grp_p_c[0] & grp_c_c[0]);
            grp_c_c[2] = grp_g_c[1] | (grp_p_c[1] & grp_g_c[0])
                       | (grp_p_c[1] & grp_p_c[0] & grp_c_c[0]);
            grp_c_c[3] = grp_g_c[2] | (grp_p_c[2] & grp_g_c[1])
                       | (grp_p_c[2] & grp_p_c[1] & grp_g_c[0])
                       | (grp_p_c[2] & grp_p_c[1] & grp_p_c[0] & grp_c_c[0]);
            grp_c_c[4] = grp_g_c[3] | (grp_p_c[3] & grp_g_c[2])
                       | (grp_p_c[3] & grp_p_c[2] & grp_g_c[1])
                       | (grp_p_c[3] & grp_p_c[2] & grp_p_c[1] & grp_g_c[0])
                       | (grp_p_c[3] & grp_p_c[2] & grp_p_c[1] & grp_p_c[0] & grp_c_c[0]);
            sum_c[4*g +: 4] = grp_p_c ^ grp_c_c[3:0];
            carry_c         = grp_c_c[4];
        end
    end

    // When the subtract succeeds the difference is below the divisor and fits
    // WIDTH bits; when it fails the shifted remainder itself fits WIDTH bits.
    assign unused_sum_c = sum_c[PAD_W-1:WIDTH];
    assign q_bit_c      = carry_c;
    assign rem_next_c   = carry_c ? sum_c[WIDTH-1:0] : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) producing the HI/LO pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of iter_divider_if
//                (start/is_signed/dividend/divisor/cancel in,
//                 busy/done/div_by_zero/lo/hi out, all outputs registered)
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_divider_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             signed_op;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] lo_fix_c;
    logic [WIDTH-1:0] hi_fix_c;
    logic [WIDTH-1:0] rem_next_c;
    logic             q_bit_c;

    // Operand magnitudes; the most negative value negates to itself, which
    // read as unsigned is exactly its magnitude.
    assign a_mag_c = (signed_op && a_raw[WIDTH-1]) ? (~a_raw + WIDTH'(1)) : a_raw;
    assign b_mag_c = (signed_op && b_raw[WIDTH-1]) ? (~b_raw + WIDTH'(1)) : b_raw;

    // Final sign correction of quotient and remainder.
    assign lo_fix_c = q_neg ? (~quo + WIDTH'(1)) : quo;
    assign hi_fix_c = r_neg ? (~rem + WIDTH'(1)) : rem;

    div_sub_step #(.WIDTH(WIDTH)) u_sub_step (
        .rem_sh     ({rem, quo[WIDTH-1]}),
        .divisor    (dvs),
        .rem_next_c (rem_next_c),
        .q_bit_c    (q_bit_c)
    );

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_raw     <= '0;
            b_raw     <= '0;
            signed_op <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            count     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_div  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // start beats a simultaneous cancel; cancel alone is a no-op here
                    if (bus.start) begin
                        a_raw     <= bus.dividend;
                        b_raw     <= bus.divisor;
                        signed_op <= bus.is_signed;
                        busy_q    <= 1'b1;
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        q_neg    <= signed_op & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                        r_neg    <= signed_op & a_raw[WIDTH-1];
                        quo      <= a_mag_c;
                        dvs      <= b_mag_c;
                        rem      <= '0;
                        count    <= '0;
                        zero_div <= (b_raw == '0);
                        // Zero divisor skips the iterations; FIX loads its result.
                        state    <= (b_raw == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rem   <= rem_next_c;
                        quo   <= {quo[WIDTH-2:0], q_bit_c};
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (zero_div) begin
                            lo_q  <= WIDTH'(DIV_ZERO_QUOTIENT);
                            hi_q  <= a_raw;
                            dbz_q <= 1'b1;
                        end else begin
                            lo_q  <= lo_fix_c;
                            hi_q  <= hi_fix_c;
                            dbz_q <= 1'b0;
                        end
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.lo          = lo_q;
    assign bus.hi          = hi_q;

endmodule
